// File: rtl/nested_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nested_irq_pkg
// Description : Shared types and helpers for the nested interrupt controller.
//               Holds the controller FSM state encoding, width helpers and the
//               handler vector address function.
// Revision    : 1.0 - initial release
// ============================================================================
package nested_irq_pkg;

  localparam int N_IRQ_DEF = 3;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_ENTER = 2'd1,
    ST_EXIT  = 2'd2
  } state_e;

  // Level width: levels run 0 (base) .. N_IRQ.
  function automatic int lvl_w(input int n_irq);
    return $clog2(n_irq + 1);
  endfunction

  // Depth width: depth runs 0 .. DEPTH.
  function automatic int depth_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Handler address for a source: base plus a fixed per-source stride.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input int unsigned shift,
                                           input logic [31:0] idx);
    return base + (idx << shift);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nested_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : nested_irq_ctrl_if
// Description : Bundle between the CPU/EPC stack and the nested interrupt
//               controller.
//   slave  (controller side): receives irq_in, irq_mask, ie, take_ok, ret_pc,
//          eret, epc_out; drives epc_en, epc_sel, epc_in, pc_load, pc_target,
//          stall, cur_level, depth, pending.
//   master (system side): the mirror image.
// Revision    : 1.0 - initial release
// ============================================================================
interface nested_irq_ctrl_if
  import nested_irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  localparam int LVL_W   = lvl_w(N_IRQ);
  localparam int DEPTH_W = depth_w(DEPTH);

  logic [N_IRQ-1:0]   irq_in;
  logic [N_IRQ-1:0]   irq_mask;
  logic               ie;
  logic               take_ok;
  logic [31:0]        ret_pc;
  logic               eret;
  logic [31:0]        epc_out;
  logic               epc_en;
  logic               epc_sel;
  logic [31:0]        epc_in;
  logic               pc_load;
  logic [31:0]        pc_target;
  logic               stall;
  logic [LVL_W-1:0]   cur_level;
  logic [DEPTH_W-1:0] depth;
  logic [N_IRQ-1:0]   pending;

  modport slave (
    input  irq_in, irq_mask, ie, take_ok, ret_pc, eret, epc_out,
    output epc_en, epc_sel, epc_in, pc_load, pc_target, stall,
           cur_level, depth, pending
  );

  modport master (
    output irq_in, irq_mask, ie, take_ok, ret_pc, eret, epc_out,
    input  epc_en, epc_sel, epc_in, pc_load, pc_target, stall,
           cur_level, depth, pending
  );
endinterface
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Masked fixed-priority encoder; the highest set index of
//               (req & mask) wins.
//   req   in  N_IRQ  request bits
//   mask  in  N_IRQ  per-bit enable
//   idx   out IDX_W  winning index (0 when none)
//   valid out 1      at least one enabled request
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
  import nested_irq_pkg::*;
#(
  parameter int N_IRQ = N_IRQ_DEF,
  parameter int IDX_W = clog2_min1(N_IRQ)
) (
  input  wire logic [N_IRQ-1:0] req,
  input  wire logic [N_IRQ-1:0] mask,
  output logic      [IDX_W-1:0] idx,
  output logic                  valid
);

  logic [N_IRQ-1:0] act;

  assign act = req & mask;

  // Ascending scan: later (higher) indices overwrite earlier ones.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N_IRQ; i++) begin
      if (act[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nested_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nested_irq_ctrl
// Description : Nested interrupt controller. Latches rising edges of the
//               request lines, arbitrates by fixed priority against the level
//               in service, and sequences the external EPC stack (push on
//               entry, pop on ERET) while redirecting and stalling the CPU.
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   bus  slave side of nested_irq_ctrl_if (requests, EPC stack, PC redirect,
//        stall and status)
// Revision    : 1.0 - initial release
// ============================================================================
module nested_irq_ctrl
  import nested_irq_pkg::*;
#(
  parameter int          N_IRQ     = N_IRQ_DEF,
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [31:0] VEC_BASE  = 32'h0000_1000,
  parameter int unsigned VEC_SHIFT = 4
) (
  input wire logic          clk,
  input wire logic          rst,
  nested_irq_ctrl_if.slave  bus
);

  localparam int LW = lvl_w(N_IRQ);
  localparam int DW = depth_w(DEPTH);
  localparam int IW = clog2_min1(N_IRQ);
  localparam int PW = clog2_min1(DEPTH);

  state_e            state_q, state_d;
  logic [N_IRQ-1:0]  irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [LW-1:0]     cur_level_q, cur_level_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic [IW-1:0]     cand_idx_q, cand_idx_d;
  logic [31:0]       ret_pc_q, ret_pc_d;
  logic [LW-1:0]     lvl_stack_q [DEPTH];
  logic [LW-1:0]     lvl_stack_d [DEPTH];

  logic [IW-1:0]     enc_idx;
  logic              enc_valid;
  logic [LW-1:0]     cand_lvl;
  logic              cand_ok;
  logic              go_exit;
  logic              go_enter;
  logic [N_IRQ-1:0]  clr;
  logic [PW-1:0]     push_ptr;
  logic [PW-1:0]     pop_ptr;

  irq_prio_enc #(.N_IRQ(N_IRQ), .IDX_W(IW)) u_prio_enc (
    .req   (pending_q),
    .mask  (bus.irq_mask),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // Source i runs at level i+1, so it preempts only strictly lower levels.
  assign cand_lvl = LW'(enc_idx) + LW'(1);
  assign cand_ok  = enc_valid & bus.ie & bus.take_ok &
                    (cand_lvl > cur_level_q) & (depth_q < DW'(DEPTH));

  // ERET wins over a simultaneous candidate; the candidate is re-arbitrated
  // after the level has been restored.
  assign go_exit  = (state_q == ST_RUN) & bus.eret & (depth_q != '0);
  assign go_enter = (state_q == ST_RUN) & ~go_exit & cand_ok;

  assign push_ptr = PW'(depth_q);
  assign pop_ptr  = PW'(depth_q - DW'(1));

  always_comb begin
    state_d     = state_q;
    irq_prev_d  = bus.irq_in;
    cur_level_d = cur_level_q;
    depth_d     = depth_q;
    cand_idx_d  = cand_idx_q;
    ret_pc_d    = ret_pc_q;
    lvl_stack_d = lvl_stack_q;
    clr         = '0;

    case (state_q)
      ST_RUN: begin
        if (go_exit) begin
          state_d = ST_EXIT;
        end else if (go_enter) begin
          state_d    = ST_ENTER;
          cand_idx_d = enc_idx;
          ret_pc_d   = bus.ret_pc;
        end
      end
      ST_ENTER: begin
        lvl_stack_d[push_ptr] = cur_level_q;
        cur_level_d           = LW'(cand_idx_q) + LW'(1);
        depth_d               = depth_q + DW'(1);
        clr                   = N_IRQ'(1) << cand_idx_q;
        state_d               = ST_RUN;
      end
      ST_EXIT: begin
        cur_level_d = lvl_stack_q[pop_ptr];
        depth_d     = depth_q - DW'(1);
        state_d     = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    // Clear first, then OR in new edges so a same-cycle edge survives.
    pending_d = (pending_q & ~clr) | (bus.irq_in & ~irq_prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      irq_prev_q  <= '0;
      pending_q   <= '0;
      cur_level_q <= '0;
      depth_q     <= '0;
      cand_idx_q  <= '0;
      ret_pc_q    <= '0;
      lvl_stack_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      irq_prev_q  <= irq_prev_d;
      pending_q   <= pending_d;
      cur_level_q <= cur_level_d;
      depth_q     <= depth_d;
      cand_idx_q  <= cand_idx_d;
      ret_pc_q    <= ret_pc_d;
      lvl_stack_q <= lvl_stack_d;
    end
  end

  // Redirect/EPC strobes are decoded from the registered state only; stall
  // additionally covers the RUN cycle that commits to ENTER or EXIT.
  assign bus.epc_en    = (state_q != ST_RUN);
  assign bus.epc_sel   = (state_q == ST_EXIT);
  assign bus.epc_in    = (state_q == ST_ENTER) ? ret_pc_q : '0;
  assign bus.pc_load   = (state_q != ST_RUN);
  assign bus.pc_target = (state_q == ST_ENTER) ?
                           vec_addr(VEC_BASE, VEC_SHIFT, 32'(cand_idx_q)) :
                         (state_q == ST_EXIT) ? bus.epc_out : '0;
  assign bus.stall     = (state_q != ST_RUN) | go_exit | go_enter;
  assign bus.cur_level = cur_level_q;
  assign bus.depth     = depth_q;
  assign bus.pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_nested_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nested_irq_ctrl
// Description : Self-checking bench for nested_irq_ctrl. Five sources are used
//               so that the four-deep nesting limit can actually be reached.
//               A transaction-level model (level/EPC queues plus a pending
//               action) predicts every output each cycle; directed literal
//               checks pin the expected addresses and levels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nested_irq_ctrl;

  localparam int NI = 5;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  nested_irq_ctrl_if #(.N_IRQ(NI), .DEPTH(DP)) bus ();

  nested_irq_ctrl #(
    .N_IRQ(NI), .DEPTH(DP), .VEC_BASE(32'h0000_1000), .VEC_SHIFT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic [NI-1:0] m_prev, m_pend, rise;
  int            m_stack[$];   // saved levels
  logic [31:0]   m_epc[$];     // EPC stack contents
  int            m_cur;
  int            m_phase;      // 0 idle, 1 entering, 2 returning
  int            m_idx;
  logic [31:0]   m_rpc;

  function automatic int cand_idx();
    for (int i = NI - 1; i >= 0; i--)
      if (m_pend[i] && bus.irq_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit cand_ok();
    int c;
    c = cand_idx();
    return (c >= 0) && bus.ie && bus.take_ok && (c + 1 > m_cur) &&
           (m_stack.size() < DP);
  endfunction

  function automatic bit exit_req();
    return bus.eret && (m_stack.size() > 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev  = '0;
      m_pend  = '0;
      m_stack.delete();
      m_epc.delete();
      m_cur   = 0;
      m_phase = 0;
      m_idx   = 0;
      m_rpc   = 32'h0;
      bus.epc_out <= 32'h0;
    end else begin
      rise = bus.irq_in & ~m_prev;
      if (m_phase == 1) begin
        m_stack.push_back(m_cur);
        m_epc.push_back(m_rpc);
        m_cur = m_idx + 1;
        m_pend[m_idx] = 1'b0;
        m_phase = 0;
      end else if (m_phase == 2) begin
        m_cur = m_stack.pop_back();
        void'(m_epc.pop_back());
        m_phase = 0;
      end else begin
        if (exit_req()) m_phase = 2;
        else if (cand_ok()) begin
          m_idx   = cand_idx();
          m_rpc   = bus.ret_pc;
          m_phase = 1;
        end
      end
      m_pend = m_pend | rise;
      m_prev = bus.irq_in;
      bus.epc_out <= (m_epc.size() > 0) ? m_epc[m_epc.size()-1] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        e_busy, e_stall;
  logic [31:0] e_tgt, e_in;

  always @(negedge clk) begin
    if (!rst) begin
      e_busy  = (m_phase != 0);
      e_stall = e_busy ? 1'b1 : (exit_req() || cand_ok());
      e_tgt   = (m_phase == 1) ? 32'h1000 + (32'(m_idx) << 4) :
                (m_phase == 2) ? bus.epc_out : 32'h0;
      e_in    = (m_phase == 1) ? m_rpc : 32'h0;
      chk("cyc_epc_en",    32'(bus.epc_en),    32'(e_busy));
      chk("cyc_epc_sel",   32'(bus.epc_sel),   32'(m_phase == 2));
      chk("cyc_epc_in",    bus.epc_in,         e_in);
      chk("cyc_pc_load",   32'(bus.pc_load),   32'(e_busy));
      chk("cyc_pc_target", bus.pc_target,      e_tgt);
      chk("cyc_stall",     32'(bus.stall),     32'(e_stall));
      chk("cyc_cur_level", 32'(bus.cur_level), 32'(m_cur));
      chk("cyc_depth",     32'(bus.depth),     32'(m_stack.size()));
      chk("cyc_pending",   32'(bus.pending),   32'(m_pend));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int i);
    bus.irq_in[i] = 1'b1;
    step(1);
    bus.irq_in[i] = 1'b0;
  endtask

  task automatic do_eret();
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
    step(1);
  endtask

  // Returns at the negedge of the ENTER cycle; n counts negedges waited.
  task automatic wait_enter(input string name, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (bus.epc_en === 1'b1 && bus.epc_sel === 1'b0) return;
    end
    checks++;
    failures++;
    $display("FAIL %s: got no ENTER expected ENTER within 20 cycles", name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.irq_in   = '0;
    bus.irq_mask = '0;
    bus.ie       = 1'b0;
    bus.take_ok  = 1'b0;
    bus.ret_pc   = 32'h0;
    bus.eret     = 1'b0;
    step(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_epc_en",  32'(bus.epc_en),    32'h0);
    chk("rst_pc_load", 32'(bus.pc_load),   32'h0);
    chk("rst_stall",   32'(bus.stall),     32'h0);
    chk("rst_depth",   32'(bus.depth),     32'h0);
    chk("rst_level",   32'(bus.cur_level), 32'h0);
    chk("rst_pending", 32'(bus.pending),   32'h0);

    // Single IRQ
    bus.ie = 1'b1; bus.irq_mask = 5'b11111; bus.take_ok = 1'b1;
    bus.ret_pc = 32'h40;
    pulse(0);
    wait_enter("s1_enter", n);
    chk("s1_latency", 32'(n), 32'd2);
    chk("s1_epc_in",  bus.epc_in, 32'h40);
    chk("s1_target",  bus.pc_target, 32'h1000);
    step(1);
    chk("s1_level", 32'(bus.cur_level), 32'd1);
    chk("s1_depth", 32'(bus.depth), 32'd1);

    // Nesting, first held off by take_ok=0
    bus.take_ok = 1'b0; bus.ret_pc = 32'h1008;
    pulse(2);
    step(2);
    chk("s2_hold_depth",   32'(bus.depth), 32'd1);
    chk("s2_hold_pending", 32'(bus.pending), 32'b00100);
    bus.take_ok = 1'b1;
    wait_enter("s2_enter", n);
    chk("s2_epc_in", bus.epc_in, 32'h1008);
    chk("s2_target", bus.pc_target, 32'h1020);
    step(1);
    chk("s2_level", 32'(bus.cur_level), 32'd3);
    chk("s2_depth", 32'(bus.depth), 32'd2);

    // Lower priority blocked
    pulse(1);
    step(2);
    chk("s3_pending", 32'(bus.pending), 32'b00010);
    chk("s3_level",   32'(bus.cur_level), 32'd3);

    // ERET, then the blocked source enters
    bus.ret_pc = 32'h2000; bus.eret = 1'b1;
    @(negedge clk);
    chk("s4_decide_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1; bus.eret = 1'b0;
    @(negedge clk);
    chk("s4_exit_sel",    32'(bus.epc_sel), 32'd1);
    chk("s4_exit_target", bus.pc_target, 32'h1008);
    step(1);
    chk("s4_level", 32'(bus.cur_level), 32'd1);
    chk("s4_depth", 32'(bus.depth), 32'd1);
    wait_enter("s4_enter", n);
    chk("s4_target", bus.pc_target, 32'h1010);
    chk("s4_epc_in", bus.epc_in, 32'h2000);
    step(1);
    chk("s4_level2", 32'(bus.cur_level), 32'd2);

    // Simultaneous eret and valid candidate: EXIT first
    bus.ie = 1'b0;
    pulse(2);
    step(2);
    chk("s5_masked_pending", 32'(bus.pending), 32'b00100);
    bus.ie = 1'b1; bus.eret = 1'b1;
    @(negedge clk);
    chk("s5_decide_stall", 32'(bus.stall), 32'd1);
    @(posedge clk); #1; bus.eret = 1'b0;
    @(negedge clk);
    chk("s5_exit_first", 32'(bus.epc_sel), 32'd1);
    chk("s5_exit_target", bus.pc_target, 32'h2000);
    step(1);
    chk("s5_level", 32'(bus.cur_level), 32'd1);
    wait_enter("s5_enter", n);
    chk("s5_target", bus.pc_target, 32'h1020);
    step(1);
    chk("s5_level2", 32'(bus.cur_level), 32'd3);
    chk("s5_depth2", 32'(bus.depth), 32'd2);

    // Unwind, then eret at depth 0 is ignored
    do_eret();
    do_eret();
    chk("s6_depth", 32'(bus.depth), 32'd0);
    chk("s6_level", 32'(bus.cur_level), 32'd0);
    bus.eret = 1'b1;
    @(negedge clk);
    chk("s6_idle_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1; bus.eret = 1'b0;
    @(negedge clk);
    chk("s6_idle_epc_en",  32'(bus.epc_en), 32'd0);
    chk("s6_idle_pc_load", 32'(bus.pc_load), 32'd0);

    // Fill to the nesting limit
    for (int i = 0; i < 4; i++) begin
      bus.ret_pc = 32'h100 * (i + 1);
      pulse(i);
      wait_enter("s7_enter", n);
      chk("s7_target", bus.pc_target, 32'h1000 + 32'h10 * i);
      step(1);
    end
    chk("s7_depth", 32'(bus.depth), 32'd4);
    chk("s7_level", 32'(bus.cur_level), 32'd4);
    pulse(4);
    step(3);
    chk("s7_full_pending", 32'(bus.pending), 32'b10000);
    chk("s7_full_depth",   32'(bus.depth), 32'd4);

    // Return once, let source 4 enter, reset during ENTER
    bus.eret = 1'b1;
    step(1);
    bus.eret = 1'b0;
    @(negedge clk);
    chk("s8_exit_target", bus.pc_target, 32'h400);
    wait_enter("s8_enter", n);
    chk("s8_target", bus.pc_target, 32'h1040);
    rst = 1'b1;
    #1;
    chk("s8_rst_epc_en",  32'(bus.epc_en), 32'd0);
    chk("s8_rst_pc_load", 32'(bus.pc_load), 32'd0);
    chk("s8_rst_stall",   32'(bus.stall), 32'd0);
    chk("s8_rst_target",  bus.pc_target, 32'h0);
    chk("s8_rst_pending", 32'(bus.pending), 32'd0);
    chk("s8_rst_depth",   32'(bus.depth), 32'd0);
    chk("s8_rst_level",   32'(bus.cur_level), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step(2);
    chk("s8_after_depth", 32'(bus.depth), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nested_irq_ctrl.md
Name: nested_irq_ctrl

Overview:
- Nested-interrupt controller for the single-cycle/pipelined CPU.
- Latches edge-triggered interrupt requests and arbitrates them by fixed priority against the level currently in service.
- Sequences the 4-deep EPC stack through its en/sel push/pop interface on interrupt entry and ERET.
- Drives PC redirect and a pipeline stall strobe.

Parameters:
- N_IRQ, 3, number of interrupt sources; higher index = higher priority.
- DEPTH, 4, maximum nesting depth; must equal the EPC stack depth.
- VEC_BASE, 32'h0000_1000, handler vector for source 0.
- VEC_SHIFT, 4, vector stride = 1 << VEC_SHIFT bytes per source.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  N_IRQ  raw request lines; rising edge sets pending.
- irq_mask  in  N_IRQ  per-source enable; 1 = enabled.
- ie  in  1  global interrupt enable.
- take_ok  in  1  pipeline is at an instruction boundary and may be redirected.
- ret_pc  in  32  PC to resume at; pushed into the EPC stack on entry.
- eret  in  1  ERET retiring this cycle.
- epc_out  in  32  EPC stack top-of-stack (combinational).
- epc_en  out  1  EPC stack enable.
- epc_sel  out  1  0 = push, 1 = pop.
- epc_in  out  32  data to push.
- pc_load  out  1  redirect PC this cycle.
- pc_target  out  32  redirect address.
- stall  out  1  freeze the pipeline front end.
- cur_level  out  clog2(N_IRQ+1)  level in service; 0 = base, source i = i+1.
- depth  out  clog2(DEPTH+1)  current nesting depth.
- pending  out  N_IRQ  latched pending bits.

Behaviour:
- Reset (asynchronous): state=RUN; pending=0; depth=0; cur_level=0; level stack cleared; all outputs 0.
- Pending logic:
  - irq_prev is registered each cycle; a rising edge on bit i sets pending[i].
  - pending[i] is cleared on the ENTER cycle that services source i.
  - If a new edge arrives on the same bit in that same cycle, the bit remains set.
- Candidate: highest index i with pending[i] & irq_mask[i]. Candidate is valid if ie=1, (i+1) > cur_level, depth < DEPTH, and take_ok=1.
- FSM states: RUN, ENTER, EXIT. ENTER and EXIT each last exactly 1 cycle, then return to RUN.
- RUN transitions:
  - eret=1 and depth!=0 -> EXIT.
  - Otherwise, valid candidate -> ENTER; register cand_idx and ret_pc.
  - eret has precedence over a candidate in the same cycle. The candidate is re-evaluated in RUN after EXIT completes.
  - eret with depth=0 is ignored: no pop, no redirect.
- ENTER outputs: epc_en=1, epc_sel=0, epc_in=registered ret_pc, pc_load=1, pc_target=VEC_BASE + (cand_idx << VEC_SHIFT), stall=1.
- ENTER state updates (at the clock edge): push cur_level onto the internal level stack; cur_level=cand_idx+1; depth+1; clear pending[cand_idx].
- EXIT outputs: epc_en=1, epc_sel=1, pc_load=1, pc_target=epc_out (sampled before the pop edge), stall=1.
- EXIT state updates: cur_level = popped level; depth-1.
- stall is also 1 in the RUN cycle that decides ENTER or EXIT, so no instruction issues between decision and redirect.
- Latency: irq edge at cycle t sets pending at t+1; earliest ENTER at t+2.
- Boundary conditions:
  - depth==DEPTH: further requests stay pending and are not taken.
  - Equal or lower priority than cur_level: stays pending until an EXIT lowers the level.
  - Masked or ie=0: pending is still latched.
  - Reset mid-ENTER/EXIT: everything aborts to the reset state. The EPC stack must be reset in the same cycle by the system reset.
- Arithmetic: depth and cur_level are unsigned, no wrap; guards prevent overflow and underflow.

Decomposition:
- Shared package nested_irq_pkg: FSM state enum (RUN/ENTER/EXIT), LVL_W = clog2(N_IRQ+1), DEPTH_W = clog2(DEPTH+1), vector-address function.
- One sub-module, irq_prio_enc: N_IRQ-bit masked priority encoder producing idx and valid.

Test Plan:
- Single IRQ: rst, ie=1, mask=3'b111, ret_pc=0x40, pulse irq_in[0] -> ENTER 2 cycles later; epc push of 0x40; pc_target=0x1000; cur_level=1; depth=1.
- Nesting: while at level 1, pulse irq_in[2] with ret_pc=0x1008 -> push 0x1008, pc_target=0x1020, cur_level=3, depth=2. Then eret with epc_out=0x1008 -> pop, pc_target=0x1008, cur_level=1, depth=1.
- Lower priority blocked: at level 3 pulse irq_in[1] -> pending=3'b010, no ENTER. After eret returns to level 1, ENTER to 0x1010 follows.
- Simultaneous: eret and a valid candidate in the same RUN cycle -> EXIT first, then ENTER of the candidate if still valid.
- Limits: 4 nested entries, then a 5th request -> stays pending, depth=4. eret with depth=0 -> epc_en stays 0, no pc_load.
- Async reset asserted in an ENTER cycle -> all outputs 0 immediately; pending=0; depth=0.
